// File: rtl/state_logic_pkg.sv
// ---------------------------------------------------------------------------
// state_logic_pkg
//   Shared constants for the multicycle processor control FSM: the 6-bit
//   state codes and the 6-bit opcode values (instr[31:26]). Reused by the
//   state register, the downstream output decoder and the testbenches.
// ---------------------------------------------------------------------------
package state_logic_pkg;

    localparam int STATE_W = 6;
    localparam int OP_W    = 6;

    // Control state codes
    localparam logic [STATE_W-1:0] S_FETCH   = 6'd0;
    localparam logic [STATE_W-1:0] S_DECODE  = 6'd1;
    localparam logic [STATE_W-1:0] S_MEMADR  = 6'd2;
    localparam logic [STATE_W-1:0] S_MEMRD   = 6'd3;
    localparam logic [STATE_W-1:0] S_MEMWB   = 6'd4;
    localparam logic [STATE_W-1:0] S_MEMWR   = 6'd5;
    localparam logic [STATE_W-1:0] S_RTYPEEX = 6'd6;
    localparam logic [STATE_W-1:0] S_RTYPEWB = 6'd7;
    localparam logic [STATE_W-1:0] S_BEQEX   = 6'd8;
    localparam logic [STATE_W-1:0] S_ADDIEX  = 6'd9;
    localparam logic [STATE_W-1:0] S_ANDIEX  = 6'd10;
    localparam logic [STATE_W-1:0] S_ORIEX   = 6'd11;
    localparam logic [STATE_W-1:0] S_XORIEX  = 6'd12;
    localparam logic [STATE_W-1:0] S_ITYPEWB = 6'd13;
    localparam logic [STATE_W-1:0] S_JEX     = 6'd14;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

endpackage : state_logic_pkg

// File: rtl/state_logic.sv
// ---------------------------------------------------------------------------
// state_logic
//   Main control state machine of the multicycle datapath. Holds the current
//   control state and advances one step per clock, steering on the opcode in
//   DECODE and MEMADR only.
//
// Ports:
//   clk    in   1  system clock, state register updates on rising edge
//   reset  in   1  asynchronous active-low reset, forces state to FETCH
//   op     in   6  instruction opcode field, instr[31:26]
//   state  out  6  current control state, straight from the state register
// ---------------------------------------------------------------------------
module state_logic
    import state_logic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    always_comb begin
        // NOTE: default assigned before the case so every path drives state_d;
        // this prevents a latch and sends unused codes 15..63 back to FETCH.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                // An X/Z or undefined opcode matches no item and falls to FETCH.
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_XORI:      state_d = S_XORIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX,
            S_ANDIEX,
            S_ORIEX,
            S_XORIEX:  state_d = S_ITYPEWB;
            S_ITYPEWB: state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // NOTE: non-blocking assignment for the register so every flop samples
    // the pre-edge value of state_d, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule : state_logic

// File: tb/tb_state_logic.sv
// ---------------------------------------------------------------------------
// tb_state_logic
//   Directed self-checking bench for state_logic. Inputs change mid-cycle,
//   the state is sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_state_logic;
    import state_logic_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] state;

    int total_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    state_logic dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and compare the resulting state.
    task automatic step(input string tag, input logic [5:0] exp);
        @(posedge clk);
        #1;
        check(tag, state, exp);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'bx;

        // Reset asserted between edges: state must be FETCH at once.
        #2;
        reset = 1'b0;
        #1;
        check("rst_immediate", state, 6'd0);
        step("rst_hold_1", 6'd0);
        step("rst_hold_2", 6'd0);

        // Release mid-cycle; first edge moves to DECODE. A two-state
        // simulator cannot carry X on op, so an undefined opcode stands in
        // for the unknown value when checking the fall-back to FETCH.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step("rel_decode", 6'd1);
        op = 6'b010101;
        step("rel_undef_fetch", 6'd0);

        // ORI then XORI
        op = 6'd13;
        step("ori_decode", 6'd1);
        step("ori_ex",     6'd11);
        step("ori_wb",     6'd13);
        step("ori_fetch",  6'd0);
        op = 6'd14;
        step("xori_decode", 6'd1);
        step("xori_ex",     6'd12);
        step("xori_wb",     6'd13);
        step("xori_fetch",  6'd0);

        // LW then SW
        op = 6'd35;
        step("lw_decode", 6'd1);
        step("lw_memadr", 6'd2);
        step("lw_memrd",  6'd3);
        step("lw_memwb",  6'd4);
        step("lw_fetch",  6'd0);
        op = 6'd43;
        step("sw_decode", 6'd1);
        step("sw_memadr", 6'd2);
        step("sw_memwr",  6'd5);
        step("sw_fetch",  6'd0);

        // RTYPE
        op = 6'd0;
        step("rtype_decode", 6'd1);
        step("rtype_ex",     6'd6);
        step("rtype_wb",     6'd7);
        step("rtype_fetch",  6'd0);

        // BEQ
        op = 6'd4;
        step("beq_decode", 6'd1);
        step("beq_ex",     6'd8);
        step("beq_fetch",  6'd0);

        // J
        op = 6'd2;
        step("j_decode", 6'd1);
        step("j_ex",     6'd14);
        step("j_fetch",  6'd0);

        // ADDI
        op = 6'd8;
        step("addi_decode", 6'd1);
        step("addi_ex",     6'd9);
        step("addi_wb",     6'd13);
        step("addi_fetch",  6'd0);

        // ANDI
        op = 6'd12;
        step("andi_decode", 6'd1);
        step("andi_ex",     6'd10);
        step("andi_wb",     6'd13);
        step("andi_fetch",  6'd0);

        // Illegal opcode returns from DECODE to FETCH
        op = 6'd63;
        step("illegal_decode", 6'd1);
        step("illegal_fetch",  6'd0);

        // op changed while in MEMRD has no effect
        op = 6'd35;
        step("opchg_decode", 6'd1);
        step("opchg_memadr", 6'd2);
        step("opchg_memrd",  6'd3);
        op = 6'd43;
        step("opchg_memwb",  6'd4);
        step("opchg_fetch",  6'd0);

        // Async reset mid-instruction while in MEMRD
        op = 6'd35;
        step("abort_decode", 6'd1);
        step("abort_memadr", 6'd2);
        step("abort_memrd",  6'd3);
        #2;
        reset = 1'b0;
        #1;
        check("abort_async", state, 6'd0);
        step("abort_hold", 6'd0);
        #2;
        reset = 1'b1;
        step("abort_restart_decode", 6'd1);
        step("abort_restart_memadr", 6'd2);
        step("abort_restart_memrd",  6'd3);
        step("abort_restart_memwb",  6'd4);
        step("abort_restart_fetch",  6'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule : tb_state_logic
